// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller: opcodes, one-hot ring states
// and the control-word layout used by the sequencer decode.
package sap1_pkg;

  typedef logic [3:0]  opcode_t;
  typedef logic [5:0]  state_t;
  typedef logic [11:0] cw_t;

  localparam opcode_t OP_LDA = 4'b0000;
  localparam opcode_t OP_ADD = 4'b0001;
  localparam opcode_t OP_SUB = 4'b0010;
  localparam opcode_t OP_OUT = 4'b1110;
  localparam opcode_t OP_HLT = 4'b1111;

  localparam state_t T1     = 6'b000001;
  localparam state_t T2     = 6'b000010;
  localparam state_t T3     = 6'b000100;
  localparam state_t T4     = 6'b001000;
  localparam state_t T5     = 6'b010000;
  localparam state_t T6     = 6'b100000;
  localparam state_t T_HALT = 6'b000000;

  // Control-word bit positions, MSB first: Cp Ep nLm nCE nLi nEi nLa Ea Su Eu nLb nLo
  localparam int CW_CP  = 11;
  localparam int CW_EP  = 10;
  localparam int CW_NLM = 9;
  localparam int CW_NCE = 8;
  localparam int CW_NLI = 7;
  localparam int CW_NEI = 6;
  localparam int CW_NLA = 5;
  localparam int CW_EA  = 4;
  localparam int CW_SU  = 3;
  localparam int CW_EU  = 2;
  localparam int CW_NLB = 1;
  localparam int CW_NLO = 0;

  // Every active-low strobe deasserted, every active-high strobe off.
  localparam cw_t CW_INACTIVE = 12'b0011_1110_0011;

endpackage

// File: rtl/ring_counter.sv
// Six-state one-hot ring counter (T1..T6) clocked on the falling edge of nCLK,
// with an all-zero HALT state that is left only through nCLR.
module ring_counter
  import sap1_pkg::*;
(
  input  logic         nCLK,
  input  logic         nCLR,
  input  logic         halt_req,
  output logic [5:0]   state
);

  // state  | meaning
  // T1     | fetch: PC onto bus, load MAR
  // T2     | fetch: PC increment
  // T3     | fetch: RAM onto bus, load IR
  // T4..T6 | execute, decoded from OP
  // T_HALT | halted, all bits zero

  state_t state_q;
  state_t state_d;

  always_ff @(negedge nCLK or negedge nCLR) begin
    if (!nCLR) state_q <= T1;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = T1;
    if (halt_req) begin
      state_d = T_HALT;
    end else begin
      case (state_q)
        T1:      state_d = T2;
        T2:      state_d = T3;
        T3:      state_d = T4;
        T4:      state_d = T5;
        T5:      state_d = T6;
        T6:      state_d = T1;
        T_HALT:  state_d = T_HALT;
        // A corrupted multi-hot pattern restarts the instruction cycle.
        default: state_d = T1;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: ring counter plus a purely combinational decode
// of (state, OP) into the datapath control word; owns the halt condition.
module controller_sequencer
  import sap1_pkg::*;
(
  input  logic       nCLK,
  input  logic       nCLR,
  input  logic [3:0] OP,
  output logic       Cp,
  output logic       Ep,
  output logic       nLm,
  output logic       nCE,
  output logic       nLi,
  output logic       nEi,
  output logic       nLa,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       nLb,
  output logic       nLo,
  output logic       HLT,
  output logic [5:0] T
);

  state_t state;
  cw_t    cw;
  logic   halt_req;

  assign halt_req = (state == T4) && (OP == OP_HLT);

  ring_counter u_ring (
    .nCLK     (nCLK),
    .nCLR     (nCLR),
    .halt_req (halt_req),
    .state    (state)
  );

  // OP is only consulted in T4..T6, so IR churn during fetch is invisible.
  always_comb begin
    cw = CW_INACTIVE;
    case (state)
      T1: begin
        cw[CW_EP]  = 1'b1;
        cw[CW_NLM] = 1'b0;
      end
      T2: cw[CW_CP] = 1'b1;
      T3: begin
        cw[CW_NCE] = 1'b0;
        cw[CW_NLI] = 1'b0;
      end
      T4: begin
        case (OP)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw[CW_NEI] = 1'b0;
            cw[CW_NLM] = 1'b0;
          end
          OP_OUT: begin
            cw[CW_EA]  = 1'b1;
            cw[CW_NLO] = 1'b0;
          end
          default: cw = CW_INACTIVE;
        endcase
      end
      T5: begin
        case (OP)
          OP_LDA: begin
            cw[CW_NCE] = 1'b0;
            cw[CW_NLA] = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_NCE] = 1'b0;
            cw[CW_NLB] = 1'b0;
          end
          default: cw = CW_INACTIVE;
        endcase
      end
      T6: begin
        case (OP)
          OP_ADD: begin
            cw[CW_EU]  = 1'b1;
            cw[CW_NLA] = 1'b0;
          end
          OP_SUB: begin
            cw[CW_EU]  = 1'b1;
            cw[CW_NLA] = 1'b0;
            cw[CW_SU]  = 1'b1;
          end
          default: cw = CW_INACTIVE;
        endcase
      end
      default: cw = CW_INACTIVE;
    endcase
  end

  assign Cp  = cw[CW_CP];
  assign Ep  = cw[CW_EP];
  assign nLm = cw[CW_NLM];
  assign nCE = cw[CW_NCE];
  assign nLi = cw[CW_NLI];
  assign nEi = cw[CW_NEI];
  assign nLa = cw[CW_NLA];
  assign Ea  = cw[CW_EA];
  assign Su  = cw[CW_SU];
  assign Eu  = cw[CW_EU];
  assign nLb = cw[CW_NLB];
  assign nLo = cw[CW_NLO];
  assign HLT = (state == T_HALT);
  assign T   = state;

endmodule
